// File: rtl/rr_arb_16.sv
// 16-way round-robin arbiter with per-grant hold limit; grant lands 1 cycle after request.
// Requesters hold req until served; done, dropped req or hold limit releases, then one dead cycle.
module rr_arb_16 #(
  parameter int CNT_W    = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        done,
  output logic        gnt_en,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [3:0] pick_idx;
  logic       pick_vld;
  logic [3:0] cand;
  logic       rel_done, rel_drop, rel_hold;

  // Scan from the far end so the candidate closest to ptr wins.
  always_comb begin
    pick_idx = ptr_q;
    pick_vld = 1'b0;
    cand     = ptr_q;
    for (int j = 15; j >= 0; j--) begin
      cand = ptr_q + 4'(j);
      if (req[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign rel_done = done;
  assign rel_drop = ~req[idx_q];
  assign rel_hold = (cnt_q == HOLD_LIM);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          cnt_d   = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 4'd1;
          // A forced release only counts as a timeout when nothing else ended the grant.
          timeout_d = rel_hold && !rel_done && !rel_drop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      ptr_q     <= 4'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_en  = (state_q == GRANT);
  assign gnt_idx = idx_q;
  assign timeout = timeout_q;

  always_comb begin
    gnt = 16'h0000;
    if (gnt_en) gnt[idx_q] = 1'b1;
  end

endmodule
